// File: rtl/wb_arbiter_if.sv
// Bundle of the writeback arbiter's request, scoreboard and regfile-port signals.
// The arbiter takes the slave view; requesters and the regfile side take the master view.
interface wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            alu_valid_i;
    logic [4:0]      alu_rd_i;
    logic [XLEN-1:0] alu_data_i;
    logic            alu_ready_o;
    logic            lsu_valid_i;
    logic [4:0]      lsu_rd_i;
    logic [XLEN-1:0] lsu_data_i;
    logic            lsu_ready_o;
    logic            issue_valid_i;
    logic [4:0]      issue_rd_i;
    logic [4:0]      r1_addr_i;
    logic [4:0]      r2_addr_i;
    logic            r1_busy_o;
    logic            r2_busy_o;
    logic [4:0]      w_addr_o;
    logic            we_o;
    logic [XLEN-1:0] wdata_o;

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  issue_valid_i, issue_rd_i, r1_addr_i, r2_addr_i,
        output alu_ready_o, lsu_ready_o, r1_busy_o, r2_busy_o,
        output w_addr_o, we_o, wdata_o
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        output issue_valid_i, issue_rd_i, r1_addr_i, r2_addr_i,
        input  alu_ready_o, lsu_ready_o, r1_busy_o, r2_busy_o,
        input  w_addr_o, we_o, wdata_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter (ALU vs LSU with anti-starvation) and in-flight load scoreboard.
// Define WB_ARB_SCOREBOARD_EN to build the pending-load scoreboard; otherwise busy covers only the registered write.
module wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk_i,
    input  logic          reset_i,
    wb_arbiter_if.slave   bus
);
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic            lsu_prio;
    logic            alu_grant;
    logic            lsu_grant;
    logic [2:0]      starve_cnt;
    logic            we_p1;
    logic [4:0]      w_addr_p1;
    logic [XLEN-1:0] wdata_p1;
    logic            r1_pend;
    logic            r2_pend;

    function automatic logic busy_of(input logic [4:0] addr, input logic pend,
                                     input logic we, input logic [4:0] w_addr);
        return (addr != 5'd0) && (pend || (we && (w_addr == addr)));
    endfunction

    // Grants depend only on the valids and the starve counter, never on ready.
    always_comb begin
        lsu_prio  = (starve_cnt == LIMIT);
        lsu_grant = bus.lsu_valid_i && (lsu_prio || !bus.alu_valid_i);
        alu_grant = bus.alu_valid_i && !lsu_grant;
    end

    assign bus.alu_ready_o = alu_grant;
    assign bus.lsu_ready_o = lsu_grant;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt <= 3'd0;
        end else if (!bus.lsu_valid_i || lsu_grant) begin
            starve_cnt <= 3'd0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end

    // ---- stage p1: registered regfile write port ----
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            we_p1     <= 1'b0;
            w_addr_p1 <= 5'd0;
            wdata_p1  <= '0;
        end else if (alu_grant) begin
            we_p1     <= (bus.alu_rd_i != 5'd0);
            w_addr_p1 <= bus.alu_rd_i;
            wdata_p1  <= bus.alu_data_i;
        end else if (lsu_grant) begin
            we_p1     <= (bus.lsu_rd_i != 5'd0);
            w_addr_p1 <= bus.lsu_rd_i;
            wdata_p1  <= bus.lsu_data_i;
        end else begin
            we_p1     <= 1'b0;
        end
    end

    assign bus.we_o     = we_p1;
    assign bus.w_addr_o = w_addr_p1;
    assign bus.wdata_o  = wdata_p1;

`ifdef WB_ARB_SCOREBOARD_EN
    logic [31:0] pending;
    logic [31:0] pending_nxt;

    // Set is applied after clear so a same-cycle reissue to the returning rd stays pending.
    always_comb begin
        pending_nxt = pending;
        if (lsu_grant) pending_nxt[bus.lsu_rd_i] = 1'b0;
        if (bus.issue_valid_i) pending_nxt[bus.issue_rd_i] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) pending <= '0;
        else         pending <= pending_nxt;
    end

    assign r1_pend = pending[bus.r1_addr_i];
    assign r2_pend = pending[bus.r2_addr_i];
`else
    logic issue_unused;
    assign issue_unused = ^{bus.issue_valid_i, bus.issue_rd_i};
    assign r1_pend = 1'b0;
    assign r2_pend = 1'b0;
`endif

    assign bus.r1_busy_o = busy_of(bus.r1_addr_i, r1_pend, we_p1, w_addr_p1);
    assign bus.r2_busy_o = busy_of(bus.r2_addr_i, r2_pend, we_p1, w_addr_p1);
endmodule

// File: tb/tb_wb_arbiter.sv
// Table-driven bench for wb_arbiter: per-cycle vectors with hand-set grants, a queue of expected
// register-port writes, a small pending/busy model and a shadow regfile fed from the write port.
module tb_wb_arbiter;
    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        ea;
        logic        el;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

`ifdef WB_ARB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(32)) bus ();

    wb_arbiter #(.XLEN(32), .STARVE_LIMIT(3)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    logic [31:0] rf [32] = '{default: 32'd0};
    always @(posedge clk) if (bus.we_o) rf[bus.w_addr_o] <= bus.wdata_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    vec_t        tbl[$];
    wr_t         exp_q[$];
    logic [31:0] m_pend  = '0;
    logic        m_we    = 1'b0;
    logic [4:0]  m_waddr = 5'd0;
    logic [31:0] m_wdata = 32'd0;

    function automatic vec_t mk(logic rst_v, logic av, logic [4:0] ard, logic [31:0] adat,
                                logic lv, logic [4:0] lrd, logic [31:0] ldat,
                                logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2,
                                logic ea, logic el);
        vec_t t;
        t.rst = rst_v; t.av = av; t.ard = ard; t.adat = adat;
        t.lv = lv; t.lrd = lrd; t.ldat = ldat; t.iv = iv; t.ird = ird;
        t.r1 = r1; t.r2 = r2; t.ea = ea; t.el = el;
        return t;
    endfunction

    function automatic logic exp_busy(logic [4:0] a);
        return (a != 5'd0) && ((SB_EN && m_pend[a]) || (m_we && (m_waddr == a)));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        wr_t rec;
        wr_t got;
        @(negedge clk);
        rst               = t.rst;
        bus.alu_valid_i   = t.av;   bus.alu_rd_i = t.ard; bus.alu_data_i = t.adat;
        bus.lsu_valid_i   = t.lv;   bus.lsu_rd_i = t.lrd; bus.lsu_data_i = t.ldat;
        bus.issue_valid_i = t.iv;   bus.issue_rd_i = t.ird;
        bus.r1_addr_i     = t.r1;   bus.r2_addr_i = t.r2;
        #1;
        if (!t.rst) begin
            chk($sformatf("v%0d alu_ready", idx), 32'(bus.alu_ready_o), 32'(t.ea));
            chk($sformatf("v%0d lsu_ready", idx), 32'(bus.lsu_ready_o), 32'(t.el));
        end
        chk($sformatf("v%0d r1_busy", idx), 32'(bus.r1_busy_o), 32'(exp_busy(t.r1)));
        chk($sformatf("v%0d r2_busy", idx), 32'(bus.r2_busy_o), 32'(exp_busy(t.r2)));
        if (t.rst)     rec = '{1'b0, 5'd0, 32'd0};
        else if (t.ea) rec = '{(t.ard != 5'd0), t.ard, t.adat};
        else if (t.el) rec = '{(t.lrd != 5'd0), t.lrd, t.ldat};
        else           rec = '{1'b0, m_waddr, m_wdata};
        exp_q.push_back(rec);
        if (t.rst) m_pend = '0;
        else begin
            if (t.el) m_pend[t.lrd] = 1'b0;
            if (t.iv) m_pend[t.ird] = 1'b1;
            m_pend[0] = 1'b0;
        end
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk($sformatf("v%0d we_o", idx),     32'(bus.we_o),     32'(got.we));
        chk($sformatf("v%0d w_addr_o", idx), 32'(bus.w_addr_o), 32'(got.addr));
        chk($sformatf("v%0d wdata_o", idx),  bus.wdata_o,       got.data);
        m_we = got.we; m_waddr = got.addr; m_wdata = got.data;
    endtask

    initial begin
        bus.alu_valid_i = 1'b0; bus.alu_rd_i = 5'd0; bus.alu_data_i = 32'd0;
        bus.lsu_valid_i = 1'b0; bus.lsu_rd_i = 5'd0; bus.lsu_data_i = 32'd0;
        bus.issue_valid_i = 1'b0; bus.issue_rd_i = 5'd0;
        bus.r1_addr_i = 5'd0; bus.r2_addr_i = 5'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        //                rst av ard    adat          lv lrd    ldat          iv ird   r1     r2    ea el
        // reset held with an ALU request pending, then one idle cycle
        tbl.push_back(mk(1, 1, 5'd1,  32'h1111_1111, 0, 5'd0,  32'd0,        0, 5'd0, 5'd1,  5'd0, 0, 0));
        tbl.push_back(mk(1, 1, 5'd1,  32'h1111_1111, 0, 5'd0,  32'd0,        0, 5'd0, 5'd1,  5'd0, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,        0, 5'd0, 5'd1,  5'd1, 0, 0));
        // single writes, including one to x0
        tbl.push_back(mk(0, 1, 5'd1,  32'hDEAD_BEEF, 0, 5'd0,  32'd0,        0, 5'd0, 5'd1,  5'd0, 1, 0));
        tbl.push_back(mk(0, 1, 5'd0,  32'h1234_5678, 0, 5'd0,  32'd0,        0, 5'd0, 5'd1,  5'd0, 1, 0));
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,        0, 5'd0, 5'd1,  5'd0, 0, 0));
        // collision under continuous pressure: ALU x3, LSU, ALU, LSU
        tbl.push_back(mk(0, 1, 5'd10, 32'hA0,        1, 5'd20, 32'hB0,       0, 5'd0, 5'd0,  5'd0, 1, 0));
        tbl.push_back(mk(0, 1, 5'd11, 32'hA1,        1, 5'd20, 32'hB0,       0, 5'd0, 5'd0,  5'd0, 1, 0));
        tbl.push_back(mk(0, 1, 5'd12, 32'hA2,        1, 5'd20, 32'hB0,       0, 5'd0, 5'd0,  5'd0, 1, 0));
        tbl.push_back(mk(0, 1, 5'd13, 32'hA3,        1, 5'd20, 32'hB0,       0, 5'd0, 5'd0,  5'd0, 0, 1));
        tbl.push_back(mk(0, 1, 5'd13, 32'hA3,        1, 5'd21, 32'hB1,       0, 5'd0, 5'd0,  5'd0, 1, 0));
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         1, 5'd21, 32'hB1,       0, 5'd0, 5'd0,  5'd0, 0, 1));
        // scoreboard: issue rd2, return rd2
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,        1, 5'd2, 5'd2,  5'd0, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,        0, 5'd0, 5'd2,  5'd21, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         1, 5'd2,  32'hCAFE_BABE, 0, 5'd0, 5'd2,  5'd0, 0, 1));
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,        0, 5'd0, 5'd2,  5'd0, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,        0, 5'd0, 5'd2,  5'd0, 0, 0));
        // same-rd set and clear in one cycle
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,        1, 5'd5, 5'd5,  5'd0, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         1, 5'd5,  32'h55,       1, 5'd5, 5'd5,  5'd0, 0, 1));
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,        0, 5'd0, 5'd5,  5'd5, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,        0, 5'd0, 5'd5,  5'd0, 0, 0));
        // reset mid-operation: rd3/rd7 pending, LSU starved to count 2
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,        1, 5'd3, 5'd5,  5'd0, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,        1, 5'd7, 5'd3,  5'd7, 0, 0));
        tbl.push_back(mk(0, 1, 5'd8,  32'hC0,        1, 5'd9,  32'hD0,       0, 5'd0, 5'd3,  5'd7, 1, 0));
        tbl.push_back(mk(0, 1, 5'd14, 32'hC1,        1, 5'd9,  32'hD0,       0, 5'd0, 5'd3,  5'd7, 1, 0));
        tbl.push_back(mk(1, 1, 5'd15, 32'hC2,        1, 5'd9,  32'hD0,       0, 5'd0, 5'd3,  5'd7, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,        0, 5'd0, 5'd3,  5'd7, 0, 0));
        tbl.push_back(mk(0, 1, 5'd16, 32'hC3,        1, 5'd9,  32'hD0,       0, 5'd0, 5'd0,  5'd0, 1, 0));
        tbl.push_back(mk(0, 1, 5'd17, 32'hC4,        1, 5'd9,  32'hD0,       0, 5'd0, 5'd0,  5'd0, 1, 0));
        tbl.push_back(mk(0, 1, 5'd18, 32'hC5,        1, 5'd9,  32'hD0,       0, 5'd0, 5'd0,  5'd0, 1, 0));
        tbl.push_back(mk(0, 1, 5'd18, 32'hC5,        1, 5'd9,  32'hD0,       0, 5'd0, 5'd0,  5'd0, 0, 1));
        tbl.push_back(mk(0, 1, 5'd18, 32'hC5,        0, 5'd0,  32'd0,        0, 5'd0, 5'd0,  5'd0, 1, 0));
        tbl.push_back(mk(0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,        0, 5'd0, 5'd0,  5'd0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Regfile contents after commits; x0 must never have been written.
        @(negedge clk);
        chk("rf r1",  rf[1],  32'hDEAD_BEEF);
        chk("rf r2",  rf[2],  32'hCAFE_BABE);
        chk("rf r0",  rf[0],  32'd0);
        chk("rf r20", rf[20], 32'hB0);
        chk("rf r13", rf[13], 32'hA3);
        chk("rf r9",  rf[9],  32'hD0);
        chk("rf r15", rf[15], 32'd0);
        chk("rf r18", rf[18], 32'hC5);
        chk("exp_q drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback-port arbiter and load scoreboard for the `regfile` block of the nano_rv32i core. It shares the register file's single write port between the ALU writeback path and the load/store unit using valid/ready handshakes, and registers the selected write into the regfile port. It also tracks destination registers of in-flight loads so that the decode stage can stall on read-after-write hazards.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `STARVE_LIMIT`, 3: number of consecutive denied LSU cycles before the LSU is promoted to priority; legal range 1..7.

Ports:
- `clk_i`, in, 1: clock, rising-edge.
- `reset_i`, in, 1: synchronous, active-high reset.
- `alu_valid_i`, in, 1: ALU write request.
- `alu_rd_i`, in, 5: ALU destination register.
- `alu_data_i`, in, XLEN: ALU write data.
- `alu_ready_o`, out, 1: ALU request accepted this cycle.
- `lsu_valid_i`, in, 1: load-return write request.
- `lsu_rd_i`, in, 5: load destination register.
- `lsu_data_i`, in, XLEN: load data.
- `lsu_ready_o`, out, 1: LSU request accepted this cycle.
- `issue_valid_i`, in, 1: a load is issued this cycle.
- `issue_rd_i`, in, 5: destination register of the issued load.
- `r1_addr_i`, in, 5: decode source-register address 1.
- `r2_addr_i`, in, 5: decode source-register address 2.
- `r1_busy_o`, out, 1: source register 1 has a pending write.
- `r2_busy_o`, out, 1: source register 2 has a pending write.
- `w_addr_o`, out, 5: regfile write address (drives `w_addr_i`).
- `we_o`, out, 1: regfile write enable (drives `we_i`).
- `wdata_o`, out, XLEN: regfile write data (drives `wdata_i`).

## Operation
- **Grant:** combinational, from `alu_valid_i`, `lsu_valid_i` and the starve counter.
  - Default is fixed priority to the ALU.
  - When the starve counter equals `STARVE_LIMIT`, the LSU has priority.
  - Only the winner's `ready_o` is high. The loser's `ready_o` is 0. Both are 0 when there is no request.
  - A transfer occurs when `valid && ready`. Requesters hold rd and data stable until accepted.
- **Starve counter:** 3-bit.
  - Increments when `lsu_valid_i && !lsu_ready_o`.
  - Saturates at `STARVE_LIMIT`.
  - Cleared on an LSU transfer or when `lsu_valid_i` is 0.
- **Output register:** on a transfer, `w_addr_o`/`wdata_o` load the winner's rd/data and `we_o` is set to `rd != 0`.
  - With no transfer, `we_o` goes to 0 and the address/data hold their values.
  - A transfer to x0 is accepted but produces no write.
- **Scoreboard:** 32-bit `pending` vector; bit 0 is always 0.
  - Set `pending[issue_rd_i]` when `issue_valid_i` is high.
  - Clear `pending[lsu_rd_i]` on an LSU transfer.
  - If set and clear hit the same rd in the same cycle, set wins (a newer load is outstanding).
  - ALU transfers do not touch `pending`.
- **Busy outputs:**
  - `rN_busy_o = (addr != 0) && (pending[addr] || (we_o && w_addr_o == addr))`.
  - The second term covers the write that is registered but not yet committed into the regfile.
- **Reset:** `reset_i` clears `pending`, the starve counter, `we_o`, `w_addr_o` and `wdata_o` at the next edge. In-flight requests are dropped, including any transfer in that same cycle.

## Timing
- **Reset values:**
  - `we_o` = 0, `w_addr_o` = 0, `wdata_o` = 0.
  - `r1_busy_o` = `r2_busy_o` = 0.
  - `alu_ready_o` = `lsu_ready_o` = 0 while the valids are low.
- **Handshake:** ready is combinational, valid-to-ready in the same cycle. Ready never depends on ready.
- **Latency:**
  - A transfer at edge N gives `we_o` high in cycle N..N+1.
  - The regfile commits at edge N+1.
  - Sustained throughput is one write per cycle.
- **Busy updates:**
  - `pending` updates at the edge.
  - Busy outputs are combinational from `pending`, the output register and the read addresses.
  - `issue_valid_i` at edge N gives busy from cycle N+1 onward.
  - An LSU return at edge N keeps busy high via the output register through cycle N+1, and busy drops after edge N+1.
- **Worst-case LSU wait:** `STARVE_LIMIT` cycles under continuous ALU pressure.

## Configuration
- Macro: `WB_ARB_SCOREBOARD_EN`.
- **Defined:** scoreboard and busy logic behave as described above.
- **Undefined:**
  - `pending` and its logic are not built.
  - `issue_valid_i`/`issue_rd_i` are ignored.
  - `rN_busy_o` reduces to the output-register term only: `(addr != 0) && we_o && w_addr_o == addr`.
  - Arbitration and the write path are unchanged.

## Test plan
- **Reset:** assert `reset_i` for 2 cycles with `alu_valid_i`=1. Require `we_o`=0, busy=0, and no write in the following cycle.
- **Single writes:**
  - ALU rd=1, data=0xDEADBEEF for 1 cycle. Require `alu_ready_o`=1 the same cycle, then `we_o`=1, `w_addr_o`=1, `wdata_o`=0xDEADBEEF the next cycle; a regfile read of r1 returns 0xDEADBEEF.
  - ALU rd=0, data=0x12345678. Require the transfer to be accepted and `we_o`=0.
- **Collision and starvation** (`STARVE_LIMIT`=3): hold ALU and LSU valid continuously.
  - Require ALU grants in cycles 0–2, an LSU grant in cycle 3, ALU again in cycle 4.
  - Require the write sequence to match, with no lost or duplicated data.
- **Scoreboard:**
  - Issue a load to rd=2. Require `r1_busy_o`=1 for `r1_addr_i`=2 from the next cycle.
  - LSU returns rd=2, data=0xCAFEBABE. Require busy held through the `we_o` cycle, then 0.
  - Require the regfile r2 to read 0xCAFEBABE.
- **Same-rd set/clear:** a new issue to rd=5 in the same cycle as an LSU return to rd=5. Require `pending[5]` to stay 1, so busy stays high.
- **Reset mid-operation:** pending on rd=3, 7; LSU starved at count 2; assert `reset_i`. Require all busy=0, the counter at 0, and ALU priority restored on the next collision.
